// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types and encodings for the RV32 decode stage
package decode_pkg;

    // ALU operation codes; the low four bits of the base ops equal {funct7[5], funct3}
    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000,
        ALU_SLL    = 5'b00001,
        ALU_SLT    = 5'b00010,
        ALU_SLTU   = 5'b00011,
        ALU_XOR    = 5'b00100,
        ALU_SRL    = 5'b00101,
        ALU_OR     = 5'b00110,
        ALU_AND    = 5'b00111,
        ALU_SUB    = 5'b01000,
        ALU_SRA    = 5'b01101,
        ALU_PASSB  = 5'b01111,
        ALU_MUL    = 5'b10000,
        ALU_MULH   = 5'b10001,
        ALU_MULHSU = 5'b10010,
        ALU_MULHU  = 5'b10011,
        ALU_DIV    = 5'b10100,
        ALU_DIVU   = 5'b10101,
        ALU_REM    = 5'b10110,
        ALU_REMU   = 5'b10111
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic alu_op_t alu_base(input logic alt, input logic [2:0] funct3);
        return alu_op_t'({1'b0, alt, funct3});
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32 immediate extraction and sign extension to XLEN
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Reassemble the scattered immediate bits for each instruction format
    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - parametrised RV32 decode stage with one-entry output register
module decode_stage
    import decode_pkg::*;
#(
    parameter int  XLEN     = 32,
    parameter int  NUM_REGS = 32,
    parameter int  ENABLE_M = 0,
    localparam int RAW      = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [RAW-1:0]  rf_raddr1,
    output logic [RAW-1:0]  rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_alu_op,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic            out_use_imm,
    output logic            out_wb_en,
    output logic            out_illegal
);

    localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic [4:0] rd_idx;

    assign opc     = in_instr[6:2];
    assign f3      = in_instr[14:12];
    assign f7      = in_instr[31:25];
    assign rs1_idx = in_instr[19:15];
    assign rs2_idx = in_instr[24:20];
    assign rd_idx  = in_instr[11:7];

    assign rf_raddr1 = in_instr[15 +: RAW];
    assign rf_raddr2 = in_instr[20 +: RAW];

    imm_fmt_t        dec_fmt;
    alu_op_t         dec_alu;
    logic            dec_use_imm;
    logic            dec_illegal;
    logic            dec_wb_en;
    logic            has_rs1;
    logic            has_rs2;
    logic            has_rd;
    logic [XLEN-1:0] dec_imm;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (dec_fmt),
        .imm   (dec_imm)
    );

    // Classify the incoming word: immediate format, ALU op, register usage and legality
    always_comb begin
        dec_fmt     = IMM_NONE;
        dec_alu     = ALU_ADD;
        dec_use_imm = 1'b0;
        dec_illegal = 1'b0;
        has_rs1     = 1'b0;
        has_rs2     = 1'b0;
        has_rd      = 1'b0;
        case (opc)
            OPC_LOAD, OPC_MISC_MEM, OPC_JALR, OPC_SYSTEM: begin
                dec_fmt     = IMM_I;
                dec_use_imm = 1'b1;
                has_rs1     = 1'b1;
                has_rd      = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_fmt     = IMM_I;
                dec_use_imm = 1'b1;
                has_rs1     = 1'b1;
                has_rd      = 1'b1;
                if (f3 == 3'b001) begin
                    dec_alu     = ALU_SLL;
                    dec_illegal = (f7 != F7_BASE);
                end else if (f3 == 3'b101) begin
                    dec_alu     = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    dec_illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
                end else begin
                    dec_alu = alu_base(1'b0, f3);
                end
            end
            OPC_AUIPC: begin
                dec_fmt     = IMM_U;
                dec_use_imm = 1'b1;
                has_rd      = 1'b1;
            end
            OPC_LUI: begin
                dec_fmt     = IMM_U;
                dec_alu     = ALU_PASSB;
                dec_use_imm = 1'b1;
                has_rd      = 1'b1;
            end
            OPC_STORE: begin
                dec_fmt     = IMM_S;
                dec_use_imm = 1'b1;
                has_rs1     = 1'b1;
                has_rs2     = 1'b1;
            end
            OPC_BRANCH: begin
                dec_fmt = IMM_B;
                dec_alu = ALU_SUB;
                has_rs1 = 1'b1;
                has_rs2 = 1'b1;
            end
            OPC_JAL: begin
                dec_fmt     = IMM_J;
                dec_use_imm = 1'b1;
                has_rd      = 1'b1;
            end
            OPC_OP: begin
                has_rs1 = 1'b1;
                has_rs2 = 1'b1;
                has_rd  = 1'b1;
                case (f7)
                    F7_BASE: dec_alu = alu_base(1'b0, f3);
                    // funct7[5] only selects SUB and SRA; other funct3 values ignore it
                    F7_ALT:  dec_alu = alu_base((f3 == 3'b000) || (f3 == 3'b101), f3);
                    F7_MULDIV: begin
                        if (ENABLE_M != 0) begin
                            dec_alu = alu_op_t'({2'b10, f3});
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase

        if (in_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end

        // Reduced register file: any referenced index beyond the implemented set is illegal
        if ((has_rs1 && ({1'b0, rs1_idx} >= REG_LIMIT)) ||
            (has_rs2 && ({1'b0, rs2_idx} >= REG_LIMIT)) ||
            (has_rd  && ({1'b0, rd_idx}  >= REG_LIMIT))) begin
            dec_illegal = 1'b1;
        end
    end

    assign dec_wb_en = has_rd && (rd_idx != 5'd0) && !dec_illegal;

    logic load;

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    // Output register: reset beats flush, flush beats load, load beats drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_imm     <= '0;
            out_alu_op  <= '0;
            out_opcode  <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_use_imm <= 1'b0;
            out_wb_en   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_rs1_val <= rf_rdata1;
            out_rs2_val <= rf_rdata2;
            out_rd      <= rd_idx;
            out_imm     <= dec_imm;
            out_alu_op  <= dec_alu;
            out_opcode  <= in_instr[6:0];
            out_funct3  <= f3;
            out_funct7  <= f7;
            out_use_imm <= dec_use_imm;
            out_wb_en   <= dec_wb_en;
            out_illegal <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage (base, M-enabled and RV32E instances)
module tb_decode_stage;
    import decode_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;

    wire        o_in_ready [3];
    wire [4:0]  o_ra1      [3];
    wire [4:0]  o_ra2      [3];
    wire        o_valid    [3];
    wire [31:0] o_pc       [3];
    wire [31:0] o_rs1      [3];
    wire [31:0] o_rs2      [3];
    wire [4:0]  o_rd       [3];
    wire [31:0] o_imm      [3];
    wire [4:0]  o_alu      [3];
    wire [6:0]  o_opc      [3];
    wire [2:0]  o_f3       [3];
    wire [6:0]  o_f7       [3];
    wire        o_use_imm  [3];
    wire        o_wb       [3];
    wire        o_ill      [3];

    // Instance 0: base RV32I, 1: ENABLE_M=1, 2: RV32E (NUM_REGS=16)
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NR = (g == 2) ? 16 : 32;
        localparam int EM = (g == 1) ? 1 : 0;
        localparam int AW = $clog2(NR);
        wire [AW-1:0] ra1;
        wire [AW-1:0] ra2;
        decode_stage #(.XLEN(32), .NUM_REGS(NR), .ENABLE_M(EM)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready[g]),
            .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
            .rf_raddr1(ra1), .rf_raddr2(ra2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
            .out_valid(o_valid[g]), .out_ready(out_ready), .out_pc(o_pc[g]),
            .out_rs1_val(o_rs1[g]), .out_rs2_val(o_rs2[g]), .out_rd(o_rd[g]),
            .out_imm(o_imm[g]), .out_alu_op(o_alu[g]), .out_opcode(o_opc[g]),
            .out_funct3(o_f3[g]), .out_funct7(o_f7[g]), .out_use_imm(o_use_imm[g]),
            .out_wb_en(o_wb[g]), .out_illegal(o_ill[g])
        );
        assign o_ra1[g] = 5'(ra1);
        assign o_ra2[g] = 5'(ra2);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        ill;
        logic        wb;
        logic        use_imm;
        logic [31:0] imm;
        alu_op_t     alu;
    } dec_t;

    typedef struct {
        bit          valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        dec_t        d;
    } held_t;

    alu_op_t base_ops [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    alu_op_t m_ops    [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    function automatic dec_t decode_ref(input logic [31:0] ins, input int nregs, input bit en_m);
        dec_t d;
        bit r1u, r2u, rdu;
        int hi;
        int i_imm;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        d.ill = 1'b0; d.use_imm = 1'b1; d.alu = ALU_ADD; d.imm = 32'd0;
        r1u = 1'b0; r2u = 1'b0; rdu = 1'b0;
        i_imm = $signed(ins) >>> 20;
        case (ins[6:2])
            5'd0, 5'd3, 5'd25, 5'd28: begin d.imm = i_imm; r1u = 1; rdu = 1; end
            5'd4: begin
                d.imm = i_imm; r1u = 1; rdu = 1;
                if (f3 == 3'd1) begin d.alu = ALU_SLL; d.ill = (f7 != 7'h00); end
                else if (f3 == 3'd5) begin
                    d.alu = (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                    d.ill = !(f7 == 7'h00 || f7 == 7'h20);
                end else d.alu = base_ops[f3];
            end
            5'd5:  begin d.imm = ins & 32'hFFFF_F000; rdu = 1; end
            5'd13: begin d.imm = ins & 32'hFFFF_F000; d.alu = ALU_PASSB; rdu = 1; end
            5'd8: begin
                hi = $signed(ins) >>> 25;
                d.imm = hi * 32 + int'(ins[11:7]); r1u = 1; r2u = 1;
            end
            5'd24: begin
                hi = $signed(ins) >>> 31;
                d.imm = hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                d.alu = ALU_SUB; d.use_imm = 1'b0; r1u = 1; r2u = 1;
            end
            5'd27: begin
                hi = $signed(ins) >>> 31;
                d.imm = hi * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
                rdu = 1;
            end
            5'd12: begin
                d.use_imm = 1'b0; r1u = 1; r2u = 1; rdu = 1;
                if (f7 == 7'h00) d.alu = base_ops[f3];
                else if (f7 == 7'h20) d.alu = (f3 == 3'd0) ? ALU_SUB : (f3 == 3'd5) ? ALU_SRA : base_ops[f3];
                else if (f7 == 7'h01 && en_m) d.alu = m_ops[f3];
                else d.ill = 1'b1;
            end
            default: d.ill = 1'b1;
        endcase
        if (ins[1:0] != 2'b11) d.ill = 1'b1;
        if ((r1u && int'(ins[19:15]) >= nregs) || (r2u && int'(ins[24:20]) >= nregs) ||
            (rdu && int'(ins[11:7]) >= nregs)) d.ill = 1'b1;
        d.wb = rdu && (ins[11:7] != 5'd0) && !d.ill;
        return d;
    endfunction

    task automatic check_bundle(input int g, input held_t h, input string tag);
        chk($sformatf("%s.valid[%0d]", tag, g), 32'(o_valid[g]), 32'(h.valid));
        if (h.valid) begin
            chk($sformatf("%s.pc[%0d]", tag, g), o_pc[g], h.pc);
            chk($sformatf("%s.rs1_val[%0d]", tag, g), o_rs1[g], h.r1);
            chk($sformatf("%s.rs2_val[%0d]", tag, g), o_rs2[g], h.r2);
            chk($sformatf("%s.rd[%0d]", tag, g), 32'(o_rd[g]), 32'(h.instr[11:7]));
            chk($sformatf("%s.opcode[%0d]", tag, g), 32'(o_opc[g]), 32'(h.instr[6:0]));
            chk($sformatf("%s.funct3[%0d]", tag, g), 32'(o_f3[g]), 32'(h.instr[14:12]));
            chk($sformatf("%s.funct7[%0d]", tag, g), 32'(o_f7[g]), 32'(h.instr[31:25]));
            chk($sformatf("%s.illegal[%0d]", tag, g), 32'(o_ill[g]), 32'(h.d.ill));
            chk($sformatf("%s.wb_en[%0d]", tag, g), 32'(o_wb[g]), 32'(h.d.wb));
            if (!h.d.ill) begin
                chk($sformatf("%s.imm[%0d]", tag, g), o_imm[g], h.d.imm);
                chk($sformatf("%s.alu_op[%0d]", tag, g), 32'(o_alu[g]), 32'(h.d.alu));
                chk($sformatf("%s.use_imm[%0d]", tag, g), 32'(o_use_imm[g]), 32'(h.d.use_imm));
            end
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins;
        logic [4:0]  pick;
        ins = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 11))
                0: pick = 5'd0;   1: pick = 5'd3;   2: pick = 5'd4;   3: pick = 5'd5;
                4: pick = 5'd8;   5: pick = 5'd12;  6: pick = 5'd13;  7: pick = 5'd24;
                8: pick = 5'd25;  9: pick = 5'd27;  10: pick = 5'd28; default: pick = 5'd12;
            endcase
            ins[6:0] = {pick, 2'b11};
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 2))
                    0: ins[31:25] = 7'h00;
                    1: ins[31:25] = 7'h20;
                    default: ins[31:25] = 7'h01;
                endcase
            end
        end
        if ($urandom_range(0, 1) != 0) begin
            ins[24] = 1'b0; ins[19] = 1'b0; ins[11] = 1'b0;
        end
        return ins;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input logic ordy, input logic fl);
        in_valid = iv; in_instr = ins; in_pc = pc;
        rf_rdata1 = r1; rf_rdata2 = r2; out_ready = ordy; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_t     alu;
        logic        use_imm;
        logic        wb;
        logic        ill;
    } vec_t;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_SUB  = 32'h4020_81B3;
    localparam logic [31:0] I_BEQ  = 32'hFE00_0EE3;
    localparam logic [31:0] I_MUL  = 32'h0273_02B3;
    localparam logic [31:0] I_ADDE = 32'h0020_88B3;

    vec_t  vecs [11];
    held_t mdl  [3];
    logic  exp_rdy;

    initial begin
        vecs[0]  = '{I_ADDI,        0,  0, 5'd1,  32'd5,          ALU_ADD,   1'b1, 1'b1, 1'b0};
        vecs[1]  = '{I_SUB,         10, 3, 5'd3,  32'd0,          ALU_SUB,   1'b0, 1'b1, 1'b0};
        vecs[2]  = '{I_BEQ,         0,  0, 5'd29, 32'hFFFF_FFFC,  ALU_SUB,   1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h0000_0000, 0,  0, 5'd0,  32'd0,          ALU_ADD,   1'b0, 1'b0, 1'b1};
        vecs[4]  = '{I_MUL,         6,  7, 5'd5,  32'd0,          ALU_ADD,   1'b0, 1'b0, 1'b1};
        vecs[5]  = '{32'h1234_52B7, 0,  0, 5'd5,  32'h1234_5000,  ALU_PASSB, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{32'h0020_A423, 1,  2, 5'd8,  32'd8,          ALU_ADD,   1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'h4032_5213, 4,  0, 5'd4,  32'h0000_0403,  ALU_SRA,   1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'hFF9F_F0EF, 0,  0, 5'd1,  32'hFFFF_FFF8,  ALU_ADD,   1'b1, 1'b1, 1'b0};
        vecs[9]  = '{32'h4010_9093, 0,  0, 5'd1,  32'd0,          ALU_ADD,   1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h0000_0013, 0,  0, 5'd0,  32'd0,          ALU_ADD,   1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        // reset state
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst.valid[%0d]", g), 32'(o_valid[g]), 0);
            chk($sformatf("rst.in_ready[%0d]", g), 32'(o_in_ready[g]), 1);
            chk($sformatf("rst.pc[%0d]", g), o_pc[g], 0);
            chk($sformatf("rst.imm[%0d]", g), o_imm[g], 0);
            chk($sformatf("rst.rd[%0d]", g), 32'(o_rd[g]), 0);
            chk($sformatf("rst.alu[%0d]", g), 32'(o_alu[g]), 0);
            chk($sformatf("rst.wb[%0d]", g), 32'(o_wb[g]), 0);
            chk($sformatf("rst.ill[%0d]", g), 32'(o_ill[g]), 0);
        end
        rst = 1'b0;

        // table-driven single-instruction vectors on the base instance
        for (int i = 0; i < 11; i++) begin
            drive(1, vecs[i].instr, 32'h1000 + 32'(i * 4), vecs[i].r1, vecs[i].r2, 1, 0);
            step();
            chk($sformatf("vec%0d.valid", i), 32'(o_valid[0]), 1);
            chk($sformatf("vec%0d.pc", i), o_pc[0], 32'h1000 + 32'(i * 4));
            chk($sformatf("vec%0d.rd", i), 32'(o_rd[0]), 32'(vecs[i].rd));
            chk($sformatf("vec%0d.rs1_val", i), o_rs1[0], vecs[i].r1);
            chk($sformatf("vec%0d.rs2_val", i), o_rs2[0], vecs[i].r2);
            chk($sformatf("vec%0d.illegal", i), 32'(o_ill[0]), 32'(vecs[i].ill));
            chk($sformatf("vec%0d.wb_en", i), 32'(o_wb[0]), 32'(vecs[i].wb));
            if (!vecs[i].ill) begin
                chk($sformatf("vec%0d.imm", i), o_imm[0], vecs[i].imm);
                chk($sformatf("vec%0d.alu", i), 32'(o_alu[0]), 32'(vecs[i].alu));
                chk($sformatf("vec%0d.use_imm", i), 32'(o_use_imm[0]), 32'(vecs[i].use_imm));
            end
            drive(0, 0, 0, 0, 0, 1, 0);
            step();
            chk($sformatf("vec%0d.drained", i), 32'(o_valid[0]), 0);
        end

        // back-pressure: beq held for 3 cycles while fetch keeps offering addi
        drive(1, I_BEQ, 32'h100, 0, 0, 1, 0);
        step();
        drive(1, I_ADDI, 32'h104, 0, 0, 0, 0);
        #1;
        chk("stall.in_ready0", 32'(o_in_ready[0]), 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall%0d.valid", c), 32'(o_valid[0]), 1);
            chk($sformatf("stall%0d.imm", c), o_imm[0], 32'hFFFF_FFFC);
            chk($sformatf("stall%0d.pc", c), o_pc[0], 32'h100);
            chk($sformatf("stall%0d.in_ready", c), 32'(o_in_ready[0]), 0);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        chk("stall.accepted", 32'(o_valid[0]), 0);

        // flush while holding, with a new instruction offered
        drive(1, I_ADDI, 32'h200, 0, 0, 1, 0);
        step();
        drive(1, I_SUB, 32'h204, 10, 3, 0, 1);
        step();
        chk("flush.valid", 32'(o_valid[0]), 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        chk("flush.dropped", 32'(o_valid[0]), 0);

        // M extension enabled vs disabled
        drive(1, I_MUL, 32'h300, 6, 7, 1, 0);
        step();
        chk("mul.ill_base", 32'(o_ill[0]), 1);
        chk("mul.wb_base", 32'(o_wb[0]), 0);
        chk("mul.ill_m", 32'(o_ill[1]), 0);
        chk("mul.alu_m", 32'(o_alu[1]), 32'(ALU_MUL));
        chk("mul.wb_m", 32'(o_wb[1]), 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        step();

        // RV32E register limit
        drive(1, I_ADDE, 32'h400, 1, 2, 1, 0);
        step();
        chk("rv32e.ill_e", 32'(o_ill[2]), 1);
        chk("rv32e.wb_e", 32'(o_wb[2]), 0);
        chk("rv32e.ill_base", 32'(o_ill[0]), 0);
        chk("rv32e.wb_base", 32'(o_wb[0]), 1);

        // reset in the middle of a hold
        drive(1, I_ADDI, 32'h500, 0, 0, 0, 0);
        step();
        chk("rsthold.held", 32'(o_valid[0]), 1);
        rst = 1'b1;
        step();
        for (int g = 0; g < 3; g++) chk($sformatf("rsthold.valid[%0d]", g), 32'(o_valid[g]), 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 0);
        step();

        // randomized traffic against the transaction model
        for (int g = 0; g < 3; g++) mdl[g].valid = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int g = 0; g < 3; g++) check_bundle(g, mdl[g], "rnd");
            drive($urandom_range(0, 3) != 0, gen_instr(), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            #1;
            for (int g = 0; g < 3; g++) begin
                exp_rdy = !mdl[g].valid || out_ready;
                chk($sformatf("rnd.in_ready[%0d]", g), 32'(o_in_ready[g]), 32'(exp_rdy));
                chk($sformatf("rnd.raddr1[%0d]", g), 32'(o_ra1[g]),
                    (g == 2) ? 32'(in_instr[18:15]) : 32'(in_instr[19:15]));
                chk($sformatf("rnd.raddr2[%0d]", g), 32'(o_ra2[g]),
                    (g == 2) ? 32'(in_instr[23:20]) : 32'(in_instr[24:20]));
            end
            @(posedge clk);
            for (int g = 0; g < 3; g++) begin
                exp_rdy = !mdl[g].valid || out_ready;
                if (flush) begin
                    mdl[g].valid = 1'b0;
                end else if (in_valid && exp_rdy) begin
                    mdl[g].valid = 1'b1;
                    mdl[g].instr = in_instr;
                    mdl[g].pc    = in_pc;
                    mdl[g].r1    = rf_rdata1;
                    mdl[g].r2    = rf_rdata2;
                    mdl[g].d     = decode_ref(in_instr, (g == 2) ? 16 : 32, g == 1);
                end else if (out_ready) begin
                    mdl[g].valid = 1'b0;
                end
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
